muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with HI/LO registers for the MIPS datapath. It is driven by R-type funct codes when the main decoder signals a mul/div-class instruction. It adds what the combinational ALU path lacks: iterative signed/unsigned multiply and divide, a busy/done handshake, and architectural HI/LO state with move-to/move-from.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared mul/div definitions: funct codes, FSM states,
// and a constant clog2 helper for counter sizing.
package muldiv_pkg;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Ports: clk, reset (async low), start/funct/a/b request,
// busy/done handshake, hi/lo state, result (MFHI ? hi : lo).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);

  localparam int CW = clog2(WIDTH);
  localparam int AW = 2 * WIDTH + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             negp_q, negp_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             is_mul, is_div, is_sgn;
  logic             is_mthi, is_mtlo;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_mul  = (funct == F_MULT) || (funct == F_MULTU);
  assign is_div  = (funct == F_DIV) || (funct == F_DIVU);
  assign is_sgn  = (funct == F_MULT) || (funct == F_DIV);
  assign is_mthi = (funct == F_MTHI);
  assign is_mtlo = (funct == F_MTLO);
  assign a_neg   = is_sgn & a[WIDTH-1];
  assign b_neg   = is_sgn & b[WIDTH-1];
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;

  // Multiply step: add multiplicand into the upper half
  // when the current multiplier bit is set, then shift right.
  logic [WIDTH:0]   msum;
  logic [AW-1:0]    acc_mul;
  assign msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opd_q} : '0);
  assign acc_mul = {1'b0, msum, acc_q[WIDTH-1:1]};

  // Restoring divide step: the partial remainder lives in
  // acc[2W:W], the dividend/quotient shifts through acc[W-1:0].
  logic [WIDTH+1:0] rsh, rdiff;
  logic             ge;
  logic [WIDTH:0]   rsel;
  logic [AW-1:0]    acc_div;
  assign rsh     = {acc_q[2*WIDTH:WIDTH], acc_q[WIDTH-1]};
  assign rdiff   = rsh - {2'b00, opd_q};
  assign ge      = ~rdiff[WIDTH+1];
  assign rsel    = ge ? rdiff[WIDTH:0] : rsh[WIDTH:0];
  assign acc_div = {rsel, acc_q[WIDTH-2:0], ge};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  assign prod = negp_q ? -acc_q[2*WIDTH-1:0]
                       : acc_q[2*WIDTH-1:0];
  assign quo  = dz_q   ? '1
              : negp_q ? -acc_q[WIDTH-1:0]
                       : acc_q[WIDTH-1:0];
  assign rem  = negr_q ? -acc_q[2*WIDTH-1:WIDTH]
                       : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    negp_d  = negp_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    opd_d   = opd_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (1'b1)
            is_mul: begin
              state_d = S_RUN;
              cnt_d   = '0;
              div_d   = 1'b0;
              negp_d  = a_neg ^ b_neg;
              negr_d  = 1'b0;
              dz_d    = 1'b0;
              opd_d   = a_mag;
              acc_d   = {{(WIDTH+1){1'b0}}, b_mag};
            end
            is_div: begin
              state_d = S_RUN;
              cnt_d   = '0;
              div_d   = 1'b1;
              negp_d  = a_neg ^ b_neg;
              negr_d  = a_neg;
              dz_d    = (b == '0);
              opd_d   = b_mag;
              acc_d   = {{(WIDTH+1){1'b0}}, a_mag};
            end
            is_mthi: hi_d = a;
            is_mtlo: lo_d = a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        acc_d = div_q ? acc_div : acc_mul;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      negp_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      opd_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      negp_q  <= negp_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      opd_q   <= opd_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign result = (funct == F_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32).
// Expected HI/LO queued at issue, compared on done.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo, result;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       tag;
  } exp_t;

  exp_t sb[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset_n),
    .start  (start),
    .funct  (funct),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] model(
    input logic [5:0] f, input logic [31:0] x, y);
    longint sx, sy, q, rm;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = '0;
    case (f)
      F_MULT:  r = 64'(sx * sy);
      F_MULTU: r = {32'd0, x} * {32'd0, y};
      F_DIV: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else begin
          q  = sx / sy;
          rm = sx % sy;
          r  = {rm[31:0], q[31:0]};
        end
      end
      F_DIVU: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else r = {x % y, x / y};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        check("done_spurious", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
        check({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
      end
    end
  end

  // Called at a falling edge; start is seen by the next rise.
  task automatic issue(input logic [5:0] f,
                       input logic [31:0] av, bv,
                       input bit push,
                       input logic [31:0] eh, el,
                       input string tag);
    exp_t e;
    if (push) begin
      e.hi = eh;
      e.lo = el;
      e.tag = tag;
      sb.push_back(e);
    end
    start = 1'b1;
    funct = f;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int nb);
    bit seen;
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy) nb++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  logic [5:0] ops [4];
  logic [63:0] m;
  logic [31:0] ra, rb;
  int nb;

  initial begin
    ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
    reset_n = 1'b0;
    start   = 1'b0;
    funct   = 6'd0;
    a       = '0;
    b       = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    issue(F_MULTU, 32'hFFFFFFFF, 32'd2, 1'b1,
          32'h00000001, 32'hFFFFFFFE, "multu");
    wait_done("multu", nb);
    check("multu_busy", 64'(nb), 64'd33);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);

    issue(F_MULT, 32'hFFFFFFFD, 32'd7, 1'b1,
          32'hFFFFFFFF, 32'hFFFFFFEB, "mult");
    wait_done("mult", nb);

    issue(F_DIV, 32'hFFFFFFF9, 32'd2, 1'b1,
          32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    wait_done("div_neg", nb);
    issue(F_DIVU, 32'd7, 32'd2, 1'b1,
          32'd1, 32'd3, "divu_b2b");
    wait_done("divu_b2b", nb);
    check("b2b_busy", 64'(nb), 64'd33);

    issue(F_DIV, 32'd5, 32'd0, 1'b1,
          32'd5, 32'hFFFFFFFF, "div_zero");
    wait_done("div_zero", nb);
    issue(F_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1,
          32'd0, 32'h80000000, "div_ovf");
    wait_done("div_ovf", nb);

    issue(F_MULTU, 32'd3, 32'd4, 1'b1,
          32'd0, 32'd12, "ignored");
    repeat (3) @(negedge clk);
    start = 1'b1;
    funct = F_DIV;
    a     = 32'd9;
    b     = 32'd9;
    @(negedge clk);
    funct = F_MTHI;
    a     = 32'hAA;
    @(negedge clk);
    start = 1'b0;
    check("mthi_busy_hi", 64'(hi), 64'd0);
    check("busy_mid", 64'(busy), 64'd1);
    wait_done("ignored", nb);
    @(negedge clk);

    issue(F_MTLO, 32'h1234, 32'd0, 1'b0, '0, '0, "mtlo");
    check("mtlo_lo", 64'(lo), 64'h1234);
    check("mtlo_busy", 64'(busy), 64'd0);
    funct = F_MFLO;
    #1;
    check("mflo_result", 64'(result), 64'h1234);
    funct = F_MFHI;
    #1;
    check("mfhi_result", 64'(result), 64'd0);
    @(negedge clk);
    check("mtlo_nodone", 64'(done), 64'd0);

    issue(F_DIVU, 32'd100, 32'd7, 1'b0, '0, '0, "abort");
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(F_MULTU, 32'd6, 32'd7, 1'b1,
          32'd0, 32'd42, "post_rst");
    wait_done("post_rst", nb);
    check("post_rst_busy", 64'(nb), 64'd33);

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 15))
                        : $urandom;
      m  = model(ops[i % 4], ra, rb);
      issue(ops[i % 4], ra, rb, 1'b1,
            m[63:32], m[31:0], "rand");
      wait_done("rand", nb);
    end

    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
